// File: rtl/mips_defs.sv
// Shared definitions for the MIPS memory-access stage: opcodes, FSM states and byte-lane masks.
package mips_defs;

    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SW  = 6'b101011;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } memState_t;

    // Lane masks are big-endian: bit 3 enables bits [31:24].
    localparam logic [3:0] LANE_ALL     = 4'b1111;
    localparam logic [3:0] LANE_BYTE0   = 4'b1000;
    localparam logic [3:0] LANE_HALF_HI = 4'b1100;
    localparam logic [3:0] LANE_HALF_LO = 4'b0011;

    function automatic logic isLoadOp(input logic [5:0] op);
        case (op)
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: return 1'b1;
            default:                             return 1'b0;
        endcase
    endfunction

    function automatic logic isStoreOp(input logic [5:0] op);
        case (op)
            OP_SB, OP_SH, OP_SW: return 1'b1;
            default:             return 1'b0;
        endcase
    endfunction

    function automatic logic isMisaligned(input logic [5:0] op, input logic [1:0] lowAddr);
        case (op)
            OP_LH, OP_LHU, OP_SH: return lowAddr[0];
            OP_LW, OP_SW:         return |lowAddr;
            default:              return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// Extracts and extends the addressed byte/halfword/word from a big-endian read word.
module load_align
    import mips_defs::*;
(
    input  logic [5:0]  i_op,
    input  logic [1:0]  i_lowAddr,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_value
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_rdata[31:24];
        case (i_lowAddr)
            2'b00:   w_byte = i_rdata[31:24];
            2'b01:   w_byte = i_rdata[23:16];
            2'b10:   w_byte = i_rdata[15:8];
            default: w_byte = i_rdata[7:0];
        endcase
    end

    assign w_half = i_lowAddr[1] ? i_rdata[15:0] : i_rdata[31:16];

    always_comb begin
        o_value = 32'h0000_0000;
        case (i_op)
            OP_LB:   o_value = {{24{w_byte[7]}}, w_byte};
            OP_LBU:  o_value = {24'h00_0000, w_byte};
            OP_LH:   o_value = {{16{w_half[15]}}, w_half};
            OP_LHU:  o_value = {16'h0000, w_half};
            OP_LW:   o_value = i_rdata;
            default: o_value = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// MIPS MEM stage plus MEM/WB register: req/ack data-bus loads/stores with upstream stall.
// Define MEM_ALIGN_EXC_EN to trap misaligned halfword/word accesses instead of aligning down.
module mem_access_stage
    import mips_defs::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  logic [5:0]        aluop_i,
    input  logic [31:0]       mem_addr_i,
    input  logic [31:0]       reg2_i,
    input  logic [4:0]        wd_i,
    input  logic              wreg_i,
    input  logic [31:0]       wdata_i,
    input  logic              whilo_i,
    input  logic [31:0]       hi_i,
    input  logic [31:0]       lo_i,
    output logic              bus_req_o,
    output logic              bus_we_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [3:0]        bus_sel_o,
    output logic [31:0]       bus_wdata_o,
    input  logic              bus_ack_i,
    input  logic [31:0]       bus_rdata_i,
    output logic              stall_req_o,
    output logic              valid_o,
    output logic [4:0]        wd_o,
    output logic              wreg_o,
    output logic [31:0]       wdata_o,
    output logic              whilo_o,
    output logic [31:0]       hi_o,
    output logic [31:0]       lo_o
`ifdef MEM_ALIGN_EXC_EN
    ,
    output logic              adel_o,
    output logic              ades_o,
    output logic [31:0]       badaddr_o
`endif
);

    memState_t   r_state;
    memState_t   w_nextState;
    logic        w_isLoad;
    logic        w_isStore;
    logic        w_misaligned;
    logic        w_startAccess;
    logic        w_stall;
    logic        w_busReq;
    logic [3:0]  w_laneSel;
    logic [31:0] w_laneData;
    logic [31:0] w_loadValue;

    logic [5:0]  r_op;
    logic [1:0]  r_lowAddr;
    logic [4:0]  r_wd;
    logic        r_wreg;
    logic [31:0] r_wdata;
    logic        r_whilo;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    assign w_isLoad  = isLoadOp(aluop_i);
    assign w_isStore = isStoreOp(aluop_i);

`ifdef MEM_ALIGN_EXC_EN
    assign w_misaligned = isMisaligned(aluop_i, mem_addr_i[1:0]);
`else
    assign w_misaligned = 1'b0;
`endif

    assign w_startAccess = valid_i && (w_isLoad || w_isStore) && !w_misaligned;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_stall     = 1'b0;
        w_busReq    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_startAccess) begin
                    w_nextState = ST_REQ;
                    w_stall     = 1'b1;
                end
            end
            ST_REQ: begin
                w_busReq = 1'b1;
                w_stall  = !bus_ack_i;
                if (bus_ack_i) begin
                    w_nextState = ST_IDLE;
                end
            end
            default: w_nextState = ST_IDLE;
        endcase
        if (rst) begin
            w_stall = 1'b0;
        end
    end

    assign stall_req_o = w_stall;
    assign bus_req_o   = w_busReq;

    // Stores replicate the data across lanes so the bus only needs to honour sel.
    always_comb begin
        w_laneSel  = LANE_ALL;
        w_laneData = 32'h0000_0000;
        case (aluop_i)
            OP_SB: begin
                w_laneSel  = LANE_BYTE0 >> mem_addr_i[1:0];
                w_laneData = {4{reg2_i[7:0]}};
            end
            OP_SH: begin
                w_laneSel  = mem_addr_i[1] ? LANE_HALF_LO : LANE_HALF_HI;
                w_laneData = {2{reg2_i[15:0]}};
            end
            OP_SW: begin
                w_laneSel  = LANE_ALL;
                w_laneData = reg2_i;
            end
            default: begin
                w_laneSel  = LANE_ALL;
                w_laneData = 32'h0000_0000;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus_addr_o  <= '0;
            bus_we_o    <= 1'b0;
            bus_sel_o   <= 4'b0000;
            bus_wdata_o <= 32'h0000_0000;
            r_op        <= 6'b000000;
            r_lowAddr   <= 2'b00;
            r_wd        <= 5'd0;
            r_wreg      <= 1'b0;
            r_wdata     <= 32'h0000_0000;
            r_whilo     <= 1'b0;
            r_hi        <= 32'h0000_0000;
            r_lo        <= 32'h0000_0000;
        end else if (r_state == ST_IDLE && w_startAccess) begin
            bus_addr_o  <= {mem_addr_i[ADDR_W-1:2], 2'b00};
            bus_we_o    <= w_isStore;
            bus_sel_o   <= w_laneSel;
            bus_wdata_o <= w_laneData;
            r_op        <= aluop_i;
            r_lowAddr   <= mem_addr_i[1:0];
            r_wd        <= wd_i;
            r_wreg      <= wreg_i;
            r_wdata     <= wdata_i;
            r_whilo     <= whilo_i;
            r_hi        <= hi_i;
            r_lo        <= lo_i;
        end
    end

    load_align u_loadAlign (
        .i_op      (r_op),
        .i_lowAddr (r_lowAddr),
        .i_rdata   (bus_rdata_i),
        .o_value   (w_loadValue)
    );

    // MEM/WB register: bubbles force the write enables low so WB never commits them.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_o <= 1'b0;
            wd_o    <= 5'd0;
            wreg_o  <= 1'b0;
            wdata_o <= 32'h0000_0000;
            whilo_o <= 1'b0;
            hi_o    <= 32'h0000_0000;
            lo_o    <= 32'h0000_0000;
`ifdef MEM_ALIGN_EXC_EN
            adel_o    <= 1'b0;
            ades_o    <= 1'b0;
            badaddr_o <= 32'h0000_0000;
`endif
        end else begin
`ifdef MEM_ALIGN_EXC_EN
            adel_o <= 1'b0;
            ades_o <= 1'b0;
`endif
            case (r_state)
                ST_IDLE: begin
                    if (!valid_i || w_startAccess) begin
                        valid_o <= 1'b0;
                        wreg_o  <= 1'b0;
                        whilo_o <= 1'b0;
`ifdef MEM_ALIGN_EXC_EN
                    end else if (w_misaligned) begin
                        valid_o   <= 1'b1;
                        wd_o      <= wd_i;
                        wreg_o    <= 1'b0;
                        wdata_o   <= wdata_i;
                        whilo_o   <= 1'b0;
                        hi_o      <= hi_i;
                        lo_o      <= lo_i;
                        adel_o    <= w_isLoad;
                        ades_o    <= w_isStore;
                        badaddr_o <= mem_addr_i;
`endif
                    end else begin
                        valid_o <= 1'b1;
                        wd_o    <= wd_i;
                        wreg_o  <= wreg_i;
                        wdata_o <= wdata_i;
                        whilo_o <= whilo_i;
                        hi_o    <= hi_i;
                        lo_o    <= lo_i;
                    end
                end
                ST_REQ: begin
                    if (bus_ack_i) begin
                        valid_o <= 1'b1;
                        wd_o    <= r_wd;
                        wreg_o  <= r_wreg;
                        wdata_o <= isLoadOp(r_op) ? w_loadValue : r_wdata;
                        whilo_o <= r_whilo;
                        hi_o    <= r_hi;
                        lo_o    <= r_lo;
                    end else begin
                        valid_o <= 1'b0;
                        wreg_o  <= 1'b0;
                        whilo_o <= 1'b0;
                    end
                end
                default: begin
                    valid_o <= 1'b0;
                    wreg_o  <= 1'b0;
                    whilo_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed plan cases plus random traffic against a byte-lane model.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i;
    logic [5:0]  aluop_i;
    logic [31:0] mem_addr_i;
    logic [31:0] reg2_i;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic [31:0] wdata_i;
    logic        whilo_i;
    logic [31:0] hi_i;
    logic [31:0] lo_i;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_wdata_o;
    logic        bus_ack_i;
    logic [31:0] bus_rdata_i;
    logic        stall_req_o;
    logic        valid_o;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;
    logic        whilo_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int passCount   = 0;
    int failCount   = 0;
    int totalChecks = 0;

    logic [31:0] lastResult;
    logic [5:0]  memOps [8];
    logic [5:0]  otherOps [5];

    always #5 clk = ~clk;

    mem_access_stage #(.ADDR_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .valid_i     (valid_i),
        .aluop_i     (aluop_i),
        .mem_addr_i  (mem_addr_i),
        .reg2_i      (reg2_i),
        .wd_i        (wd_i),
        .wreg_i      (wreg_i),
        .wdata_i     (wdata_i),
        .whilo_i     (whilo_i),
        .hi_i        (hi_i),
        .lo_i        (lo_i),
        .bus_req_o   (bus_req_o),
        .bus_we_o    (bus_we_o),
        .bus_addr_o  (bus_addr_o),
        .bus_sel_o   (bus_sel_o),
        .bus_wdata_o (bus_wdata_o),
        .bus_ack_i   (bus_ack_i),
        .bus_rdata_i (bus_rdata_i),
        .stall_req_o (stall_req_o),
        .valid_o     (valid_o),
        .wd_o        (wd_o),
        .wreg_o      (wreg_o),
        .wdata_o     (wdata_o),
        .whilo_o     (whilo_o),
        .hi_o        (hi_o),
        .lo_o        (lo_o)
    );

    // Reference model: access size in bytes, 0 for anything that is not a load/store.
    function automatic int opSize(input logic [5:0] op);
        case (op)
            6'b100000, 6'b100100, 6'b101000: return 1;
            6'b100001, 6'b100101, 6'b101001: return 2;
            6'b100011, 6'b101011:            return 4;
            default:                         return 0;
        endcase
    endfunction

    function automatic logic modelIsStore(input logic [5:0] op);
        return (op[5:3] == 3'b101) && (opSize(op) != 0);
    endfunction

    function automatic logic modelIsLoad(input logic [5:0] op);
        return (op[5:3] == 3'b100) && (opSize(op) != 0);
    endfunction

    function automatic int firstByte(input logic [5:0] op, input logic [31:0] addr);
        int size;
        size = opSize(op);
        return (int'(addr % 4) / size) * size;
    endfunction

    function automatic logic [3:0] modelSel(input logic [5:0] op, input logic [31:0] addr);
        logic [3:0] sel;
        int base;
        if (modelIsLoad(op)) return 4'b1111;
        sel  = 4'b0000;
        base = firstByte(op, addr);
        for (int i = base; i < base + opSize(op); i++) sel[3 - i] = 1'b1;
        return sel;
    endfunction

    function automatic logic [31:0] modelWdata(input logic [5:0] op, input logic [31:0] reg2);
        case (opSize(op))
            1:       return (reg2 & 32'h0000_00FF) * 32'h0101_0101;
            2:       return (reg2 & 32'h0000_FFFF) * 32'h0001_0001;
            default: return reg2;
        endcase
    endfunction

    function automatic logic [31:0] modelLoad(input logic [5:0] op, input logic [31:0] addr,
                                              input logic [31:0] rdata);
        int size;
        int base;
        int bits;
        logic [31:0] mask;
        logic [31:0] value;
        logic [31:0] signBit;
        size  = opSize(op);
        base  = firstByte(op, addr);
        bits  = 8 * size;
        mask  = (size == 4) ? 32'hFFFF_FFFF : ((32'h1 << bits) - 32'h1);
        value = (rdata >> (8 * (4 - size - base))) & mask;
        signBit = 32'h1 << (bits - 1);
        if ((op == 6'b100000 || op == 6'b100001) && ((value & signBit) != 0)) value = value | ~mask;
        return value;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        totalChecks++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [5:0] op, input logic [31:0] addr,
                                 input logic [31:0] r2, input logic [4:0] wd, input logic wreg,
                                 input logic [31:0] wdata, input logic whilo,
                                 input logic [31:0] hi, input logic [31:0] lo);
        valid_i    = v;
        aluop_i    = op;
        mem_addr_i = addr;
        reg2_i     = r2;
        wd_i       = wd;
        wreg_i     = wreg;
        wdata_i    = wdata;
        whilo_i    = whilo;
        hi_i       = hi;
        lo_i       = lo;
    endtask

    task automatic applyBubble();
        applyStimulus(1'b0, 6'd0, 32'd0, 32'd0, 5'd0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic runAluOp(input logic [5:0] op, input logic [4:0] wd, input logic [31:0] wdata,
                            input logic whilo, input logic [31:0] hi, input logic [31:0] lo);
        @(negedge clk);
        applyStimulus(1'b1, op, $urandom, $urandom, wd, 1'b1, wdata, whilo, hi, lo);
        #1;
        checkOutput("aluStall", stall_req_o, 1'b0);
        @(negedge clk);
        applyBubble();
        #1;
        checkOutput("aluValid", valid_o, 1'b1);
        checkOutput("aluWd", wd_o, wd);
        checkOutput("aluWreg", wreg_o, 1'b1);
        checkOutput("aluWdata", wdata_o, wdata);
        checkOutput("aluWhilo", whilo_o, whilo);
        checkOutput("aluHi", hi_o, hi);
        checkOutput("aluLo", lo_o, lo);
        checkOutput("aluBusReq", bus_req_o, 1'b0);
    endtask

    task automatic runMemOp(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                            input logic [31:0] rdata, input int ackDelay, output logic [31:0] result);
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        isStore;
        wd      = 5'($urandom);
        wreg    = modelIsLoad(op);
        wdata   = $urandom;
        hi      = $urandom;
        lo      = $urandom;
        isStore = modelIsStore(op);
        @(negedge clk);
        applyStimulus(1'b1, op, addr, reg2, wd, wreg, wdata, 1'b0, hi, lo);
        #1;
        checkOutput("memStallIdle", stall_req_o, 1'b1);
        checkOutput("memBusReqIdle", bus_req_o, 1'b0);
        @(negedge clk);
        for (int c = 0; c <= ackDelay; c++) begin
            if (c == ackDelay) begin
                bus_ack_i   = 1'b1;
                bus_rdata_i = rdata;
                applyBubble();
            end else begin
                bus_ack_i   = 1'b0;
                bus_rdata_i = $urandom;
            end
            #1;
            checkOutput("reqBusReq", bus_req_o, 1'b1);
            checkOutput("reqAddr", bus_addr_o, addr & 32'hFFFF_FFFC);
            checkOutput("reqWe", bus_we_o, isStore);
            checkOutput("reqSel", bus_sel_o, modelSel(op, addr));
            if (isStore) checkOutput("reqWdata", bus_wdata_o, modelWdata(op, reg2));
            checkOutput("reqStall", stall_req_o, (c != ackDelay));
            checkOutput("reqValidBubble", valid_o, 1'b0);
            @(negedge clk);
        end
        bus_ack_i   = 1'b0;
        bus_rdata_i = $urandom;
        #1;
        checkOutput("doneValid", valid_o, 1'b1);
        checkOutput("doneWd", wd_o, wd);
        checkOutput("doneWreg", wreg_o, wreg);
        checkOutput("doneWdata", wdata_o, isStore ? wdata : modelLoad(op, addr, rdata));
        checkOutput("doneBusReq", bus_req_o, 1'b0);
        checkOutput("doneStall", stall_req_o, 1'b0);
        result = wdata_o;
    endtask

    initial begin
        memOps   = '{6'b100000, 6'b100001, 6'b100011, 6'b100100, 6'b100101,
                     6'b101000, 6'b101001, 6'b101011};
        otherOps = '{6'b000000, 6'b001001, 6'b001111, 6'b100010, 6'b101010};

        rst         = 1'b1;
        bus_ack_i   = 1'b0;
        bus_rdata_i = 32'd0;
        applyBubble();
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rstValid", valid_o, 1'b0);
        checkOutput("rstStall", stall_req_o, 1'b0);
        checkOutput("rstBusReq", bus_req_o, 1'b0);
        checkOutput("rstSel", bus_sel_o, 4'b0000);
        checkOutput("rstWdata", wdata_o, 32'd0);
        checkOutput("rstWreg", wreg_o, 1'b0);
        rst = 1'b0;

        runAluOp(6'b000000, 5'd3, 32'h0000_0005, 1'b0, 32'd0, 32'd0);

        @(negedge clk);
        #1;
        checkOutput("bubbleValid", valid_o, 1'b0);
        checkOutput("bubbleWreg", wreg_o, 1'b0);
        checkOutput("bubbleWhilo", whilo_o, 1'b0);

        runMemOp(6'b100000, 32'h0000_1001, 32'd0, 32'h12F4_5678, 0, lastResult);
        checkOutput("planLb", lastResult, 32'hFFFF_FFF4);
        runMemOp(6'b100100, 32'h0000_1001, 32'd0, 32'h12F4_5678, 0, lastResult);
        checkOutput("planLbu", lastResult, 32'h0000_00F4);
        runMemOp(6'b100101, 32'h0000_1002, 32'd0, 32'h12F4_5678, 0, lastResult);
        checkOutput("planLhu", lastResult, 32'h0000_5678);
        runMemOp(6'b101000, 32'h0000_2003, 32'h0000_00AB, 32'd0, 3, lastResult);
        runMemOp(6'b100011, 32'h0000_4002, 32'd0, 32'hCAFE_BABE, 1, lastResult);
        checkOutput("planLwMisaligned", lastResult, 32'hCAFE_BABE);

        // Reset lands in the second REQ cycle of a store; a late ack must be ignored.
        @(negedge clk);
        applyStimulus(1'b1, 6'b101011, 32'h0000_3000, 32'h1234_5678, 5'd0, 1'b0,
                      32'd0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        applyBubble();
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("midRstBusReqHeld", bus_req_o, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("midRstBusReq", bus_req_o, 1'b0);
        checkOutput("midRstValid", valid_o, 1'b0);
        checkOutput("midRstStall", stall_req_o, 1'b0);
        bus_ack_i = 1'b1;
        @(negedge clk);
        bus_ack_i = 1'b0;
        #1;
        checkOutput("lateAckValid", valid_o, 1'b0);
        checkOutput("lateAckWreg", wreg_o, 1'b0);
        checkOutput("lateAckBusReq", bus_req_o, 1'b0);

        for (int n = 0; n < 24; n++) begin
            if ($urandom_range(0, 9) < 8) begin
                runMemOp(memOps[$urandom_range(0, 7)], $urandom, $urandom, $urandom,
                         int'($urandom_range(0, 3)), lastResult);
            end else begin
                runAluOp(otherOps[$urandom_range(0, 4)], 5'($urandom), $urandom, 1'($urandom),
                         $urandom, $urandom);
            end
        end

        $display("%0d/%0d checks passed", passCount, totalChecks);
        $finish;
    end

endmodule
